// File: rtl/ones_packet_gen_pkg.sv
// ===========================================================================
// ones_pkg : shared widths, state encoding and the LFSR step function
//            for the ones-packet generator.
// Revision : 1.0
// ===========================================================================
`default_nettype none

package ones_pkg;

  localparam int          PKT_W     = 64;
  localparam int          CNT_W     = 11;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHUFFLE = 2'd1,
    OUT     = 2'd2
  } state_t;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ones_packet_gen_if.sv
// ===========================================================================
// ones_packet_gen_if : request and packet handshakes of the generator.
// Revision : 1.0
// ===========================================================================
`default_nettype none

interface ones_packet_gen_if;
  import ones_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [6:0]       req_count;
  logic [15:0]      req_seed;
  logic             pkt_valid;
  logic             pkt_ready;
  logic [PKT_W-1:0] pkt_data;
  logic [CNT_W-1:0] pkt_count;

  modport master (
    output req_valid, req_count, req_seed, pkt_ready,
    input  req_ready, pkt_valid, pkt_data, pkt_count
  );

  modport slave (
    input  req_valid, req_count, req_seed, pkt_ready,
    output req_ready, pkt_valid, pkt_data, pkt_count
  );

endinterface

`default_nettype wire

// File: rtl/ones_packet_gen_lfsr.sv
// ===========================================================================
// ones_lfsr16 : 16-bit Galois LFSR with seed load (zero seed replaced by
//               DEFAULT_SEED) and single-step advance; exposes the next value.
// Revision : 1.0
// ===========================================================================
`default_nettype none

module ones_lfsr16
  import ones_pkg::*;
#(
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        load,
  input  wire logic        step,
  input  wire logic [15:0] seed,
  output logic      [15:0] lfsr_n
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_n = lfsr_step(lfsr_q);

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      // An all-zero state would lock the LFSR, so zero seeds are replaced.
      lfsr_d = (seed == 16'h0000) ? DEFAULT_SEED : seed;
    end else if (step) begin
      lfsr_d = lfsr_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= DEFAULT_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ones_packet_gen.sv
// ===========================================================================
// ones_packet_gen : builds a 64-bit word with exactly n ones by shuffling a
//                   thermometer code with LFSR-driven bit swaps.
// Revision : 1.0
// ===========================================================================
`default_nettype none

module ones_packet_gen
  import ones_pkg::*;
#(
  parameter int          SWAPS        = 16,
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  ones_packet_gen_if.slave  bus
);

  localparam logic [7:0] LAST_SWAP = 8'(SWAPS - 1);

  state_t           state_q, state_d;
  logic [PKT_W-1:0] data_q,  data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       cnt_q,   cnt_d;
  logic             live_q;
  logic             lfsr_load;
  logic             lfsr_adv;
  logic [15:0]      lfsr_n;
  logic [5:0]       swap_a;
  logic [5:0]       swap_b;
  logic [6:0]       sat_n;
  logic             accept;
  logic             unused_lfsr_hi;

  ones_lfsr16 #(
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load   (lfsr_load),
    .step   (lfsr_adv),
    .seed   (bus.req_seed),
    .lfsr_n (lfsr_n)
  );

  assign swap_a         = lfsr_n[5:0];
  assign swap_b         = lfsr_n[11:6];
  assign unused_lfsr_hi = ^lfsr_n[15:12];
  assign sat_n          = (bus.req_count > 7'd64) ? 7'd64 : bus.req_count;

  // live_q keeps req_ready low while rst is held, even though state is IDLE.
  assign bus.req_ready = (state_q == IDLE) && live_q;
  assign bus.pkt_valid = (state_q == OUT);
  assign bus.pkt_data  = data_q;
  assign bus.pkt_count = count_q;
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    count_d   = count_q;
    cnt_d     = cnt_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d    = (sat_n == 7'd64) ? {PKT_W{1'b1}}
                                       : ((PKT_W'(1) << sat_n) - PKT_W'(1));
          count_d   = CNT_W'(sat_n);
          cnt_d     = 8'd0;
          lfsr_load = 1'b1;
          state_d   = SHUFFLE;
        end
      end
      SHUFFLE: begin
        data_d[swap_a] = data_q[swap_b];
        data_d[swap_b] = data_q[swap_a];
        lfsr_adv       = 1'b1;
        cnt_d          = cnt_q + 8'd1;
        if (cnt_q == LAST_SWAP) begin
          state_d = OUT;
        end
      end
      OUT: begin
        if (bus.pkt_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      count_q <= '0;
      cnt_q   <= 8'd0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ones_packet_gen.sv
// ===========================================================================
// tb_ones_packet_gen : table vectors, seed sweep and handshake/reset corner
//                      sequences checked against an expected-packet queue.
// Revision : 1.0
// ===========================================================================
`default_nettype none

module tb_ones_packet_gen;

  localparam int SWAPS = 16;

  typedef struct {
    logic [6:0]  count;
    logic [15:0] seed;
    logic [10:0] exp_n;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [10:0] count;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  ones_packet_gen_if bus ();

  ones_packet_gen #(
    .SWAPS        (SWAPS),
    .DEFAULT_SEED (16'hACE1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [6:0] c, input logic [15:0] s);
    logic [63:0] d;
    logic [15:0] l;
    logic        t;
    int          n;
    n = (c > 7'd64) ? 64 : int'(c);
    d = '0;
    for (int i = 0; i < n; i++) d[i] = 1'b1;
    l = (s == 16'h0) ? 16'hACE1 : s;
    for (int k = 0; k < SWAPS; k++) begin
      l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
      t = d[l[5:0]];
      d[l[5:0]]  = d[l[11:6]];
      d[l[11:6]] = t;
    end
    return d;
  endfunction

  // One request/packet round trip; stall>0 keeps pkt_ready low that many cycles.
  task automatic run_pkt(input logic [6:0] c, input logic [15:0] s, input int stall,
                         output logic [63:0] got);
    int          n;
    exp_t        e;
    logic [63:0] hold;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("req_ready before request", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_count = c;
    bus.req_seed  = s;
    e.data  = model(c, s);
    e.count = (c > 7'd64) ? 11'd64 : 11'(c);
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.pkt_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("latency", 64'(n), 64'(SWAPS));
    hold = bus.pkt_data;
    for (int i = 0; i < stall; i++) begin
      bus.req_valid = 1'b1;
      bus.req_count = 7'd1;
      bus.req_seed  = 16'h5555;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("stall pkt_valid", 64'(bus.pkt_valid), 64'd1);
      check("stall data stable", bus.pkt_data, hold);
      check("stall req_ready", 64'(bus.req_ready), 64'd0);
    end
    if (sb_q.size() == 0) begin
      check("scoreboard empty", 64'd0, 64'd1);
      e.data  = '0;
      e.count = '0;
    end else begin
      e = sb_q.pop_front();
    end
    got = bus.pkt_data;
    check($sformatf("pkt_data c=%0d s=%h", c, s), bus.pkt_data, e.data);
    check($sformatf("pkt_count c=%0d s=%h", c, s), 64'(bus.pkt_count), 64'(e.count));
    check("popcount matches pkt_count", 64'($countones(bus.pkt_data)), 64'(bus.pkt_count));
    bus.pkt_ready = 1'b1;
    @(posedge clk); #1;
    bus.pkt_ready = 1'b0;
    check("pkt_valid after transfer", 64'(bus.pkt_valid), 64'd0);
    check("req_ready after transfer", 64'(bus.req_ready), 64'd1);
  endtask

  vec_t        vt[7];
  logic [63:0] res[7];
  logic [63:0] sweep[256];
  logic [63:0] w;

  initial begin
    vt[0] = '{7'd0,   16'h1234, 11'd0};
    vt[1] = '{7'd64,  16'hBEEF, 11'd64};
    vt[2] = '{7'd100, 16'hBEEF, 11'd64};
    vt[3] = '{7'd1,   16'h0001, 11'd1};
    vt[4] = '{7'd32,  16'h5A5A, 11'd32};
    vt[5] = '{7'd20,  16'h0000, 11'd20};
    vt[6] = '{7'd20,  16'hACE1, 11'd20};

    bus.req_valid = 1'b0;
    bus.req_count = '0;
    bus.req_seed  = '0;
    bus.pkt_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("reset req_ready", 64'(bus.req_ready), 64'd0);
    check("reset pkt_valid", 64'(bus.pkt_valid), 64'd0);
    check("reset pkt_data", bus.pkt_data, 64'd0);
    check("reset pkt_count", 64'(bus.pkt_count), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("req_ready after reset", 64'(bus.req_ready), 64'd1);

    for (int i = 0; i < 7; i++) begin
      run_pkt(vt[i].count, vt[i].seed, 0, res[i]);
      check($sformatf("vector %0d popcount", i), 64'($countones(res[i])), 64'(vt[i].exp_n));
    end
    check("count 0 gives zero word", res[0], 64'd0);
    check("count 64 all ones", res[1], {64{1'b1}});
    check("count 100 equals count 64", res[2], res[1]);
    check("seed 0 equals seed ACE1", res[5], res[6]);

    for (int s = 1; s < 256; s++) begin
      run_pkt(7'd5, 16'(s), 0, sweep[s]);
      check($sformatf("sweep popcount s=%0d", s), 64'($countones(sweep[s])), 64'd5);
    end
    foreach (vt[i]) begin end
    for (int k = 0; k < 3; k++) begin
      int s;
      s = (k == 0) ? 1 : ((k == 1) ? 77 : 255);
      run_pkt(7'd5, 16'(s), 0, w);
      check($sformatf("repeat seed %0d", s), w, sweep[s]);
    end

    run_pkt(7'd9, 16'h3C3C, 10, w);

    // Reset while the shuffle is in progress.
    bus.req_valid = 1'b1;
    bus.req_count = 7'd40;
    bus.req_seed  = 16'h7777;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid-reset pkt_valid", 64'(bus.pkt_valid), 64'd0);
    check("mid-reset pkt_data", bus.pkt_data, 64'd0);
    check("mid-reset pkt_count", 64'(bus.pkt_count), 64'd0);
    check("mid-reset req_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.pkt_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle pkt_ready no effect", 64'(bus.pkt_valid), 64'd0);
    end
    bus.pkt_ready = 1'b0;
    run_pkt(7'd3, 16'h0BAD, 0, w);
    check("post-reset popcount", 64'($countones(w)), 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

`default_nettype wire
